sigma_gpio_irq: RTL and testbench

- Parametrised GPIO block with interrupts for the sigma SoC.
- Replaces the fixed single-button IRQ plus debouncer and the flat SW/LED wiring.
- Provides NUM_CH input channels, each with a synchroniser and a debouncer, and NUM_CH registered outputs.
- Each channel has a programmable interrupt mode (level or edge, with polarity) and a W1C pending register. All channels combine into one irq_o to the CPU.
- Attached to the sigma peripheral bus as a memory-mapped slave.

---
 rtl/sigma_gpio_pkg.sv | 23 ++
 rtl/sigma_gpio_debounce.sv | 65 ++++++
 rtl/sigma_gpio_irq.sv | 149 ++++++++++++++
 tb/tb_sigma_gpio_irq.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_gpio_pkg.sv
// Shared constants for the sigma GPIO/interrupt block: register offsets,
// interrupt mode encodings and the bus data width.
package sigma_gpio_pkg;

  localparam int unsigned BUS_DW = 32;

  localparam logic [4:0] GPIO_IN   = 5'h00;
  localparam logic [4:0] GPIO_OUT  = 5'h04;
  localparam logic [4:0] GPIO_EN   = 5'h08;
  localparam logic [4:0] GPIO_MODE = 5'h0C;
  localparam logic [4:0] GPIO_POL  = 5'h10;
  localparam logic [4:0] GPIO_BOTH = 5'h14;
  localparam logic [4:0] GPIO_PEND = 5'h18;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  // Registers are word aligned; the two byte-lane bits never select anything.
  function automatic logic [4:0] reg_offset(input logic [4:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/sigma_gpio_debounce.sv
// One GPIO input channel: multi-stage synchroniser followed by a counter
// debouncer. q_o is the accepted state; rise_o/fall_o flag the accepting cycle.
module sigma_gpio_debounce #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_POW = 2
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   st_q;
  logic                   accept;

  // NOTE: every clocked assignment uses <= so all flops sample the values from
  // before the edge; with = the shift chain would collapse into a single stage.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_POW == 0) begin : g_no_filter
      assign accept = (s != st_q);
    end else begin : g_filter
      logic [DEBOUNCE_POW-1:0] cnt_q;

      // Accept only after the new level has been seen for 2^DEBOUNCE_POW clocks.
      assign accept = (s != st_q) && (cnt_q == {DEBOUNCE_POW{1'b1}});

      always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
          cnt_q <= '0;
        end else if ((s == st_q) || accept) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      st_q <= 1'b0;
    end else if (accept) begin
      st_q <= s;
    end
  end

  assign q_o    = st_q;
  assign rise_o = accept & s;
  assign fall_o = accept & ~s;

endmodule

// File: rtl/sigma_gpio_irq.sv
// Memory-mapped GPIO slave for the sigma SoC: debounced inputs, registered
// outputs, per-channel level/edge interrupts with W1C pending, one irq_o.
module sigma_gpio_irq
  import sigma_gpio_pkg::*;
#(
  parameter int unsigned       NUM_CH       = 8,
  parameter int unsigned       SYNC_STAGES  = 2,
  parameter int unsigned       DEBOUNCE_POW = 2,
  parameter logic [NUM_CH-1:0] OUT_RESET    = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [NUM_CH-1:0] gpio_bi,
  output logic [NUM_CH-1:0] gpio_bo,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [4:0]        host_addr,
  input  logic [BUS_DW-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_resp,
  output logic [BUS_DW-1:0] host_rdata,
  output logic              irq_o
);

  logic [NUM_CH-1:0] st;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;

  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] mode_q;
  logic [NUM_CH-1:0] pol_q;
  logic [NUM_CH-1:0] both_q;
  logic [NUM_CH-1:0] pend_edge_q;
  logic [NUM_CH-1:0] pend_edge_d;
  logic [NUM_CH-1:0] pend_view;
  logic [NUM_CH-1:0] evt;
  logic [NUM_CH-1:0] w1c;
  logic [NUM_CH-1:0] wdata_ch;

  logic              wr_en;
  logic              rd_en;
  logic [4:0]        off;
  logic [BUS_DW-1:0] rd_mux;
  logic              unused_wdata;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sigma_gpio_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_POW(DEBOUNCE_POW)
      ) u_debounce (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .d_i   (gpio_bi[g]),
        .q_o   (st[g]),
        .rise_o(rise[g]),
        .fall_o(fall[g])
      );
    end
  endgenerate

  assign host_ack     = host_req;
  assign wr_en        = host_req & host_we;
  assign rd_en        = host_req & ~host_we;
  assign off          = reg_offset(host_addr);
  assign wdata_ch     = host_wdata[NUM_CH-1:0];
  assign unused_wdata = ^host_wdata;

  assign w1c = (wr_en && (off == GPIO_PEND)) ? wdata_ch : '0;
  assign evt = (rise & (pol_q | both_q)) | (fall & (~pol_q | both_q));

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pend_edge_d = '0;
    pend_view   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (mode_q[i])
        // Level channels keep the sticky flop cleared, so switching to edge
        // mode always starts from a clean pending bit.
        MODE_LEVEL: begin
          pend_edge_d[i] = 1'b0;
          pend_view[i]   = (st[i] == pol_q[i]);
        end
        MODE_EDGE: begin
          pend_edge_d[i] = evt[i] | (pend_edge_q[i] & ~w1c[i]);
          pend_view[i]   = pend_edge_q[i];
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      GPIO_IN:   rd_mux[NUM_CH-1:0] = st;
      GPIO_OUT:  rd_mux[NUM_CH-1:0] = gpio_bo;
      GPIO_EN:   rd_mux[NUM_CH-1:0] = en_q;
      GPIO_MODE: rd_mux[NUM_CH-1:0] = mode_q;
      GPIO_POL:  rd_mux[NUM_CH-1:0] = pol_q;
      GPIO_BOTH: rd_mux[NUM_CH-1:0] = both_q;
      GPIO_PEND: rd_mux[NUM_CH-1:0] = pend_view;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      gpio_bo <= OUT_RESET;
      en_q    <= '0;
      mode_q  <= '0;
      pol_q   <= '0;
      both_q  <= '0;
    end else if (wr_en) begin
      case (off)
        GPIO_OUT:  gpio_bo <= wdata_ch;
        GPIO_EN:   en_q    <= wdata_ch;
        GPIO_MODE: mode_q  <= wdata_ch;
        GPIO_POL:  pol_q   <= wdata_ch;
        GPIO_BOTH: both_q  <= wdata_ch;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pend_edge_q <= '0;
      irq_o       <= 1'b0;
    end else begin
      pend_edge_q <= pend_edge_d;
      irq_o       <= |(pend_view & en_q);
    end
  end

  // Read data is captured only on reads, so it holds between responses.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      host_resp  <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_resp <= rd_en;
      if (rd_en) begin
        host_rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_sigma_gpio_irq.sv
// Directed self-checking bench for sigma_gpio_irq with NUM_CH=8,
// SYNC_STAGES=2, DEBOUNCE_POW=2, OUT_RESET=0.
module tb_sigma_gpio_irq;
  import sigma_gpio_pkg::*;

  localparam int NUM_CH = 8;

  logic              clk_i = 1'b0;
  logic              arst_i = 1'b1;
  logic [NUM_CH-1:0] gpio_bi = '0;
  logic [NUM_CH-1:0] gpio_bo;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [4:0]        host_addr = '0;
  logic [31:0]       host_wdata = '0;
  logic              host_ack;
  logic              host_resp;
  logic [31:0]       host_rdata;
  logic              irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  sigma_gpio_irq #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (2),
    .DEBOUNCE_POW(2),
    .OUT_RESET   (8'h00)
  ) dut (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .gpio_bi   (gpio_bi),
    .gpio_bo   (gpio_bo),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_ack  (host_ack),
    .host_resp (host_resp),
    .host_rdata(host_rdata),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = addr;
    host_wdata = data;
    #1;
    n_checks++;
    if (host_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ack @%h: got %b expected 1", addr, host_ack);
    end
    @(posedge clk_i);
    #1;
    host_req = 1'b0;
    host_we  = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
    @(negedge clk_i);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = addr;
    #1;
    n_checks++;
    if (host_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_ack @%h: got %b expected 1", addr, host_ack);
    end
    @(posedge clk_i);
    #1;
    host_req = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (host_resp !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_resp @%h: got %b expected 1", addr, host_resp);
    end
    data = host_rdata;
    @(negedge clk_i);
    n_checks++;
    if (host_resp !== 1'b0 || host_rdata !== data) begin
      n_fail++;
      $display("FAIL rd_resp_end @%h: resp %b rdata %h expected resp 0 rdata %h",
               addr, host_resp, host_rdata, data);
    end
  endtask

  // Reads all eight offsets on consecutive cycles with host_req held high.
  task automatic test_back_to_back(input logic [31:0] exp [8], input string tag);
    @(negedge clk_i);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 5'h00;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 7) host_req = 1'b0;
      else        host_addr = 5'((k + 1) * 4);
      @(negedge clk_i);
      n_checks++;
      if (host_resp !== 1'b1 || host_rdata !== exp[k]) begin
        n_fail++;
        $display("FAIL %s reg %h: resp %b rdata %h expected resp 1 rdata %h",
                 tag, 5'(k * 4), host_resp, host_rdata, exp[k]);
      end
    end
    @(negedge clk_i);
    n_checks++;
    if (host_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL %s resp_tail: got %b expected 0", tag, host_resp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp [8];
    // Level mode with POL=0 and IN=0 reports every channel pending.
    exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0};
    arst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if (host_resp !== 1'b0 || host_rdata !== 32'h0 || irq_o !== 1'b0 ||
        gpio_bo !== 8'h00 || host_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: resp %b rdata %h irq %b out %h ack %b expected all 0",
               host_resp, host_rdata, irq_o, gpio_bo, host_ack);
    end
    arst_i = 1'b0;
    test_back_to_back(exp, "reset_read");
  endtask

  task automatic test_out();
    logic [31:0] rd;
    bus_write(GPIO_OUT, 32'h0000_00A5);
    n_checks++;
    if (gpio_bo !== 8'hA5) begin
      n_fail++;
      $display("FAIL out_pin_a5: got %h expected a5", gpio_bo);
    end
    bus_read(GPIO_OUT, rd);
    n_checks++;
    if (rd !== 32'h0000_00A5) begin
      n_fail++;
      $display("FAIL out_read_a5: got %h expected 000000a5", rd);
    end
    bus_write(GPIO_OUT, 32'hFFFF_FFFF);
    bus_read(GPIO_OUT, rd);
    n_checks++;
    if (rd !== 32'h0000_00FF || gpio_bo !== 8'hFF) begin
      n_fail++;
      $display("FAIL out_read_ff: got %h pin %h expected 000000ff pin ff", rd, gpio_bo);
    end
    bus_write(5'h1C, 32'h1234_5678);
    bus_write(GPIO_IN, 32'hFFFF_FFFF);
    bus_read(5'h1C, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_read: got %h expected 00000000", rd);
    end
    bus_read(GPIO_IN, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL in_readonly: got %h expected 00000000", rd);
    end
    bus_read(5'h07, rd);
    n_checks++;
    if (rd !== 32'h0000_00FF) begin
      n_fail++;
      $display("FAIL out_byte_addr: got %h expected 000000ff", rd);
    end
  endtask

  task automatic test_debounce_glitch();
    @(negedge clk_i);
    gpio_bi[0] = 1'b1;
    host_req   = 1'b1;
    host_we    = 1'b0;
    host_addr  = GPIO_IN;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 3) gpio_bi[0] = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if (host_resp !== 1'b1 || host_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL glitch cycle %0d: resp %b in %h expected resp 1 in 00000000",
                 k, host_resp, host_rdata);
      end
    end
    host_req = 1'b0;
  endtask

  // IN[0] is updated on the 6th edge after the step, so the read sampled on
  // the 7th edge is the first to see it.
  task automatic test_debounce_step();
    logic [31:0] exp;
    @(negedge clk_i);
    gpio_bi[0] = 1'b1;
    host_req   = 1'b1;
    host_we    = 1'b0;
    host_addr  = GPIO_IN;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      exp = (k >= 7) ? 32'h1 : 32'h0;
      n_checks++;
      if (host_resp !== 1'b1 || host_rdata !== exp) begin
        n_fail++;
        $display("FAIL step cycle %0d: resp %b in %h expected resp 1 in %h",
                 k, host_resp, host_rdata, exp);
      end
    end
    host_req   = 1'b0;
    gpio_bi[0] = 1'b0;
    repeat (10) @(negedge clk_i);
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd;
    bus_write(GPIO_MODE, 32'hFF);
    bus_write(GPIO_POL, 32'h04);
    bus_write(GPIO_EN, 32'h04);
    @(negedge clk_i);
    gpio_bi[2] = 1'b1;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_irq_early: got %b expected 0", irq_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_irq_rise: got %b expected 1", irq_o);
    end
    bus_read(GPIO_PEND, rd);
    n_checks++;
    if (rd !== 32'h04) begin
      n_fail++;
      $display("FAIL edge_pend_rise: got %h expected 00000004", rd);
    end
    bus_write(GPIO_PEND, 32'h04);
    @(negedge clk_i);
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_irq_w1c_lag: got %b expected 1", irq_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_irq_w1c: got %b expected 0", irq_o);
    end
    gpio_bi[2] = 1'b0;
    repeat (10) @(negedge clk_i);
    bus_read(GPIO_PEND, rd);
    n_checks++;
    if (rd !== 32'h0 || irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_fall_ignored: pend %h irq %b expected 00000000 0", rd, irq_o);
    end
    gpio_bi[2] = 1'b1;
    repeat (10) @(negedge clk_i);
    bus_write(GPIO_PEND, 32'h04);
    bus_write(GPIO_BOTH, 32'h04);
    @(negedge clk_i);
    gpio_bi[2] = 1'b0;
    repeat (10) @(negedge clk_i);
    bus_read(GPIO_PEND, rd);
    n_checks++;
    if (rd !== 32'h04 || irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_both_fall: pend %h irq %b expected 00000004 1", rd, irq_o);
    end
    bus_write(GPIO_PEND, 32'h04);
  endtask

  task automatic test_level_irq();
    logic [31:0] rd;
    bus_write(GPIO_MODE, 32'h00);
    bus_write(GPIO_POL, 32'hFD);
    bus_write(GPIO_EN, 32'h02);
    repeat (2) @(negedge clk_i);
    bus_read(GPIO_PEND, rd);
    n_checks++;
    if (rd !== 32'h02 || irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL level_pend: pend %h irq %b expected 00000002 1", rd, irq_o);
    end
    bus_write(GPIO_PEND, 32'h02);
    bus_read(GPIO_PEND, rd);
    n_checks++;
    if (rd !== 32'h02) begin
      n_fail++;
      $display("FAIL level_w1c_ignored: got %h expected 00000002", rd);
    end
    @(negedge clk_i);
    gpio_bi[1] = 1'b1;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL level_irq_lag: got %b expected 1", irq_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL level_irq_drop: got %b expected 0", irq_o);
    end
    bus_read(GPIO_PEND, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL level_pend_clear: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    @(negedge clk_i);
    gpio_bi[1] = 1'b0;
    repeat (10) @(negedge clk_i);
    bus_write(GPIO_MODE, 32'hFF);
    bus_write(GPIO_BOTH, 32'h00);
    bus_write(GPIO_POL, 32'h08);
    bus_write(GPIO_EN, 32'h08);
    @(negedge clk_i);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_pre_irq: got %b expected 0", irq_o);
    end
    gpio_bi[3] = 1'b1;
    repeat (5) @(posedge clk_i);
    // The W1C lands on the 6th edge, the same edge the rise is accepted.
    bus_write(GPIO_PEND, 32'h08);
    bus_read(GPIO_PEND, rd);
    n_checks++;
    if (rd !== 32'h08 || irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_set_wins: pend %h irq %b expected 00000008 1", rd, irq_o);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] exp [8];
    exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0};
    @(negedge clk_i);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = GPIO_OUT;
    @(posedge clk_i);
    #1;
    host_req = 1'b0;
    n_checks++;
    if (host_resp !== 1'b1 || host_rdata !== 32'hFF || irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: resp %b rdata %h irq %b expected 1 000000ff 1",
               host_resp, host_rdata, irq_o);
    end
    arst_i  = 1'b1;
    gpio_bi = '0;
    #1;
    n_checks++;
    if (host_resp !== 1'b0 || host_rdata !== 32'h0 || gpio_bo !== 8'h00 || irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: resp %b rdata %h out %h irq %b expected 0 00000000 00 0",
               host_resp, host_rdata, gpio_bo, irq_o);
    end
    @(posedge clk_i);
    #1;
    arst_i = 1'b0;
    test_back_to_back(exp, "post_reset_read");
  endtask

  initial begin
    test_reset();
    test_out();
    test_debounce_glitch();
    test_debounce_step();
    test_edge_irq();
    test_level_irq();
    test_collision();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
